pedestrian_phase_timer: RTL and testbench

Phase sequencer that generates the `master_timer` countdown and the walk `enable` consumed by the pedestrian light display block, plus the vehicle signal-head drives. Runs a four-state cycle (car green, car yellow, all red, walk) paced by a one-second `tick` strobe. It latches pedestrian button presses and serves each one after the minimum car-green time. Sits between the crosswalk button input and the pedestrian light/seven-segment display path.

---
 rtl/pedestrian_phase_timer.sv | 107 ++++++++++
 tb/tb_pedestrian_phase_timer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pedestrian_phase_timer.sv
// Car/pedestrian phase sequencer: one-second tick paced countdown through
// GREEN, YELLOW, ALL_RED and WALK with a latched pedestrian request.
module pedestrian_phase_timer #(
    parameter int GREEN_TIME  = 60,
    parameter int YELLOW_TIME = 4,
    parameter int CLEAR_TIME  = 2,
    parameter int WALK_TIME   = 40
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       walk_request,
    output logic [6:0] master_timer,
    output logic       enable,
    output logic       car_green,
    output logic       car_yellow,
    output logic       car_red,
    output logic       request_pending
);

    typedef enum logic [1:0] {
        ST_GREEN   = 2'd0,
        ST_YELLOW  = 2'd1,
        ST_ALL_RED = 2'd2,
        ST_WALK    = 2'd3
    } state_t;

    localparam logic [6:0] GREEN_LD  = 7'(GREEN_TIME);
    localparam logic [6:0] YELLOW_LD = 7'(YELLOW_TIME);
    localparam logic [6:0] CLEAR_LD  = 7'(CLEAR_TIME);
    localparam logic [6:0] WALK_LD   = 7'(WALK_TIME);

    state_t     state_q, state_d;
    logic [6:0] timer_q, timer_d;
    logic       pending_q, pending_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_GREEN;
            timer_q   <= GREEN_LD;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pending_q | walk_request;
        if (tick) begin
            if (timer_q != 7'd0) begin
                timer_d = timer_q - 7'd1;
            end else begin
                unique case (state_q)
                    ST_GREEN: begin
                        // Rest in green with the timer parked at zero until a press arrives.
                        if (pending_q) begin
                            state_d = ST_YELLOW;
                            timer_d = YELLOW_LD;
                        end
                    end
                    ST_YELLOW: begin
                        state_d = ST_ALL_RED;
                        timer_d = CLEAR_LD;
                    end
                    ST_ALL_RED: begin
                        state_d   = ST_WALK;
                        timer_d   = WALK_LD;
                        pending_d = 1'b0;
                    end
                    ST_WALK: begin
                        state_d = ST_GREEN;
                        timer_d = GREEN_LD;
                    end
                    default: begin
                        state_d = ST_GREEN;
                        timer_d = GREEN_LD;
                    end
                endcase
            end
        end
    end

    always_comb begin
        car_green  = 1'b0;
        car_yellow = 1'b0;
        car_red    = 1'b0;
        enable     = 1'b0;
        unique case (state_q)
            ST_GREEN:   car_green  = 1'b1;
            ST_YELLOW:  car_yellow = 1'b1;
            ST_ALL_RED: car_red    = 1'b1;
            ST_WALK: begin
                car_red = 1'b1;
                enable  = 1'b1;
            end
            default:    car_green  = 1'b1;
        endcase
    end

    assign master_timer    = timer_q;
    assign request_pending = pending_q;

endmodule

// File: tb/tb_pedestrian_phase_timer.sv
// Random and directed stimulus against a phase-index/remaining-count reference model,
// for a default-parameter instance and a short-phase/long-walk instance.
module tb_pedestrian_phase_timer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       walk_request = 1'b0;

    logic [6:0] a_timer, b_timer;
    logic       a_en, a_g, a_y, a_r, a_p;
    logic       b_en, b_g, b_y, b_r, b_p;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pedestrian_phase_timer dut_a (
        .clock(clock), .reset(reset), .tick(tick), .walk_request(walk_request),
        .master_timer(a_timer), .enable(a_en), .car_green(a_g), .car_yellow(a_y),
        .car_red(a_r), .request_pending(a_p)
    );

    pedestrian_phase_timer #(
        .GREEN_TIME(1), .YELLOW_TIME(1), .CLEAR_TIME(1), .WALK_TIME(127)
    ) dut_b (
        .clock(clock), .reset(reset), .tick(tick), .walk_request(walk_request),
        .master_timer(b_timer), .enable(b_en), .car_green(b_g), .car_yellow(b_y),
        .car_red(b_r), .request_pending(b_p)
    );

    // phase: 0 green, 1 yellow, 2 all red, 3 walk
    typedef struct {
        int phase;
        int rem;
        bit pend;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mstep(mdl_t m, bit rst, bit tk, bit req,
                                   int d0, int d1, int d2, int d3);
        mdl_t n;
        int dur [4];
        dur[0] = d0 % 128; dur[1] = d1 % 128; dur[2] = d2 % 128; dur[3] = d3 % 128;
        n = m;
        if (rst) begin
            n.phase = 0; n.rem = dur[0]; n.pend = 1'b0;
            return n;
        end
        n.pend = m.pend | req;
        if (tk) begin
            if (m.rem > 0) n.rem = m.rem - 1;
            else if (!(m.phase == 0 && !m.pend)) begin
                n.phase = (m.phase + 1) % 4;
                n.rem = dur[n.phase];
                if (n.phase == 3) n.pend = 1'b0;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int heads(int phase);
        // {green, yellow, red}
        case (phase)
            0: return 3'b100;
            1: return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    task automatic compare_all();
        chk("a_timer", int'(a_timer), ma.rem);
        chk("a_heads", int'({a_g, a_y, a_r}), heads(ma.phase));
        chk("a_enable", int'(a_en), int'(ma.phase == 3));
        chk("a_pending", int'(a_p), int'(ma.pend));
        chk("b_timer", int'(b_timer), mb.rem);
        chk("b_heads", int'({b_g, b_y, b_r}), heads(mb.phase));
        chk("b_enable", int'(b_en), int'(mb.phase == 3));
        chk("b_pending", int'(b_p), int'(mb.pend));
    endtask

    task automatic cycle(input bit rst, input bit tk, input bit req);
        reset = rst; tick = tk; walk_request = req;
        @(posedge clock);
        ma = mstep(ma, rst, tk, req, 60, 4, 2, 40);
        mb = mstep(mb, rst, tk, req, 1, 1, 1, 127);
        #1;
        compare_all();
    endtask

    initial begin
        int n;
        ma = '{0, 60, 1'b0};
        mb = '{0, 1, 1'b0};
        #2;
        cycle(1, 0, 1);
        cycle(1, 1, 0);
        chk("reset_timer", int'(a_timer), 60);
        chk("reset_green", int'({a_g, a_y, a_r, a_en, a_p}), 5'b10000);

        // Rest in green with no requests.
        for (int i = 0; i < 200; i++) begin
            cycle(0, 1, 0);
            cycle(0, 0, 0);
        end
        chk("rest_timer", int'(a_timer), 0);
        chk("rest_green", int'(a_g), 1);

        // Request while resting: yellow on first tick after pending.
        cycle(0, 0, 1);
        chk("rest_pend", int'(a_p), 1);
        cycle(0, 1, 0);
        chk("rest_to_yellow", int'({a_y, a_timer}), {1'b1, 7'd4});

        cycle(1, 0, 0);
        for (int i = 0; i < 3000; i++)
            cycle(($urandom % 700) == 0, ($urandom % 3) == 0, ($urandom % 25) == 0);

        // Request held high through several full cycles.
        for (int i = 0; i < 400; i++) cycle(0, 1, 1);

        // Abort a walk at timer=17 with a tick on the reset edge.
        cycle(1, 0, 0);
        n = 0;
        while (!(ma.phase == 3 && ma.rem == 17) && n < 2000) begin
            cycle(0, 1, n < 3);
            n++;
        end
        chk("reach_walk17", int'(n < 2000), 1);
        chk("walk17_enable", int'(a_en), 1);
        cycle(1, 1, 1);
        chk("abort_green", int'({a_g, a_y, a_r}), 3'b100);
        chk("abort_timer", int'(a_timer), 60);
        chk("abort_en_pend", int'({a_en, a_p}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
